// File: rtl/router_inject_arbiter.sv
// Round-robin, credit-checked injection arbiter for one router input channel.
// Holds a wormhole lock from head to tail and tracks per-VC downstream credits.
module router_inject_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_VCS   = 4,
  parameter int VC_W      = 2,
  parameter int BUF_DEPTH = 16,
  parameter int CHAN_W    = 345,
  parameter int FC_W      = 10,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*VC_W-1:0]    req_vc,
  input  logic [NUM_REQ-1:0]         req_tail,
  input  logic [NUM_REQ*CHAN_W-1:0]  req_data,
  output logic [CHAN_W-1:0]          chan_out,
  output logic                       chan_valid,
  output logic [VC_W-1:0]            chan_vc,
  input  logic [FC_W-1:0]            flow_ctrl_in,
  output logic [ID_W-1:0]            grant_id,
  output logic                       error,
  output logic                       dbg_state_o,
  output logic [NUM_VCS*CNT_W-1:0]   dbg_credit_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    owner_q;
  logic [ID_W-1:0]    grant_id_q;
  logic [CNT_W-1:0]   credit_q [NUM_VCS];
  logic [CHAN_W-1:0]  chan_out_q;
  logic               chan_valid_q;
  logic [VC_W-1:0]    chan_vc_q;
  logic               error_q;

  logic [VC_W-1:0]    vc_of [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [VC_W-1:0]    send_vc;
  logic               ret_valid;
  logic [VC_W-1:0]    ret_vc;
  logic               unused_fc;

  assign ret_valid = flow_ctrl_in[0];
  assign ret_vc    = flow_ctrl_in[1 +: VC_W];
  assign unused_fc = ^flow_ctrl_in[FC_W-1:VC_W+1];

  // Eligibility looks only at the registered credit count, so a credit
  // returning this cycle cannot enable a send until the next one.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      vc_of[i] = req_vc[i*VC_W +: VC_W];
      elig[i]  = req_valid[i] && (credit_q[vc_of[i]] != '0);
    end
  end

  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (state_q == LOCKED) begin
      gnt_valid = elig[owner_q];
      gnt_idx   = owner_q;
    end else begin
      // Walk from the farthest candidate back so the nearest one wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (elig[idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = ID_W'(idx);
        end
      end
    end
    if (reset) gnt_valid = 1'b0;
  end

  // Handshake: req_ready is combinational and one-hot (or zero); a flit moves
  // when req_valid[i] && req_ready[i], and ready is never raised without valid.
  always_comb begin
    req_ready = '0;
    if (gnt_valid) req_ready[gnt_idx] = 1'b1;
  end

  assign send_vc  = vc_of[gnt_idx];
  assign rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      grant_id_q   <= '0;
      chan_out_q   <= '0;
      chan_valid_q <= 1'b0;
      chan_vc_q    <= '0;
      error_q      <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= CNT_W'(BUF_DEPTH);
    end else begin
      chan_valid_q <= gnt_valid;
      if (gnt_valid) begin
        chan_out_q <= req_data[int'(gnt_idx)*CHAN_W +: CHAN_W];
        chan_vc_q  <= send_vc;
        grant_id_q <= gnt_idx;
        rr_ptr_q   <= rr_ptr_d;
        owner_q    <= gnt_idx;
        state_q    <= req_tail[gnt_idx] ? IDLE : LOCKED;
      end
      // A send and a return on the same VC cancel out.
      for (int v = 0; v < NUM_VCS; v++) begin
        if (gnt_valid && send_vc == VC_W'(v) && !(ret_valid && ret_vc == VC_W'(v))) begin
          credit_q[v] <= credit_q[v] - 1'b1;
        end else if (ret_valid && ret_vc == VC_W'(v) && !(gnt_valid && send_vc == VC_W'(v))) begin
          if (credit_q[v] == CNT_W'(BUF_DEPTH)) error_q <= 1'b1;
          else credit_q[v] <= credit_q[v] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) dbg_credit_o[v*CNT_W +: CNT_W] = credit_q[v];
  end

  assign chan_out    = chan_out_q;
  assign chan_valid  = chan_valid_q;
  assign chan_vc     = chan_vc_q;
  assign grant_id    = grant_id_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_router_inject_arbiter.sv
// Directed bench for router_inject_arbiter: RR order, wormhole lock, credit
// accounting, sticky overflow error, mid-packet reset and data path latency.
module tb_router_inject_arbiter;

  localparam int NR = 4;
  localparam int CW = 345;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*2-1:0] req_vc;
  logic [NR-1:0]   req_tail;
  logic [NR*CW-1:0] req_data;
  logic [CW-1:0]   chan_out;
  logic            chan_valid;
  logic [1:0]      chan_vc;
  logic [9:0]      flow_ctrl_in;
  logic [1:0]      grant_id;
  logic            error;
  logic            dbg_state_o;
  logic [19:0]     dbg_credit_o;

  int compared = 0;
  int mismatched = 0;

  router_inject_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_vc(req_vc),
    .req_tail(req_tail), .req_data(req_data),
    .chan_out(chan_out), .chan_valid(chan_valid), .chan_vc(chan_vc),
    .flow_ctrl_in(flow_ctrl_in), .grant_id(grant_id), .error(error),
    .dbg_state_o(dbg_state_o), .dbg_credit_o(dbg_credit_o)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] vc,
                         input logic t, input logic [CW-1:0] d);
    req_valid[i]           = v;
    req_vc[i*2 +: 2]       = vc;
    req_tail[i]            = t;
    req_data[i*CW +: CW]   = d;
  endtask

  task automatic ready_is(input string tag, input logic [NR-1:0] exp);
    #1;
    chk(tag, req_ready, exp);
  endtask

  function automatic logic [4:0] credit(input int v);
    return dbg_credit_o[v*5 +: 5];
  endfunction

  function automatic logic [9:0] ret(input logic [1:0] vc);
    return {7'd0, vc, 1'b1};
  endfunction

  initial begin
    logic [NR-1:0] e;
    reset = 1'b1;
    req_valid = '0; req_vc = '0; req_tail = '0; req_data = '0;
    flow_ctrl_in = '0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 2'd0, 1'b1, CW'(100 + i));
    tick();
    tick();

    // reset state
    chk("rst_chan_valid", chan_valid, 0);
    chk("rst_chan_out", chan_out, 0);
    chk("rst_chan_vc", chan_vc, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_error", error, 0);
    chk("rst_state", dbg_state_o, 0);
    chk("rst_credit0", credit(0), 16);
    ready_is("rst_ready", 4'b0000);

    // test 1: all four request single-flit packets on VC0
    reset = 1'b0;
    for (int n = 0; n < 16; n++) begin
      e = 4'b0001 << (n % 4);
      ready_is("t1_ready", e);
      tick();
      chk("t1_valid", chan_valid, 1);
      chk("t1_data", chan_out, 100 + n % 4);
      chk("t1_grant_id", grant_id, n % 4);
    end
    chk("t1_credit0_empty", credit(0), 0);
    ready_is("t1_ready_starved", 4'b0000);
    tick();
    chk("t1_idle_valid", chan_valid, 0);
    chk("t1_hold_data", chan_out, 103);
    chk("t1_credit1_full", credit(1), 16);

    req_valid = '0;
    for (int n = 0; n < 16; n++) begin
      flow_ctrl_in = ret(2'd0);
      tick();
    end
    flow_ctrl_in = '0;
    chk("refill_credit0", credit(0), 16);
    chk("refill_error", error, 0);

    // single grant to req 0 so the pointer sits at 1
    set_req(0, 1'b1, 2'd0, 1'b1, CW'('h200));
    ready_is("prime_ready", 4'b0001);
    tick();
    req_valid = '0;

    // test 2: req 1 three-flit packet, reqs 0 and 2 waiting
    set_req(0, 1'b1, 2'd0, 1'b1, CW'('h300));
    set_req(1, 1'b1, 2'd0, 1'b0, CW'('h311));
    set_req(2, 1'b1, 2'd0, 1'b1, CW'('h320));
    ready_is("t2_head_ready", 4'b0010);
    tick();
    chk("t2_head_data", chan_out, 'h311);
    chk("t2_locked", dbg_state_o, 1);
    req_data[1*CW +: CW] = CW'('h312);
    ready_is("t2_body_ready", 4'b0010);
    tick();
    chk("t2_body_data", chan_out, 'h312);
    req_tail[1] = 1'b1;
    req_data[1*CW +: CW] = CW'('h313);
    ready_is("t2_tail_ready", 4'b0010);
    tick();
    chk("t2_tail_data", chan_out, 'h313);
    chk("t2_unlocked", dbg_state_o, 0);
    req_valid[1] = 1'b0;
    ready_is("t2_next2_ready", 4'b0100);
    tick();
    chk("t2_req2_data", chan_out, 'h320);
    req_valid[2] = 1'b0;
    ready_is("t2_next0_ready", 4'b0001);
    tick();
    chk("t2_req0_data", chan_out, 'h300);
    chk("t2_grant_id", grant_id, 0);
    req_valid = '0;
    chk("t2_credit0", credit(0), 10);

    // test 3: req 3 locks VC2 and drains it; req 0 on VC1 is locked out
    set_req(3, 1'b1, 2'd2, 1'b0, CW'('h400));
    set_req(0, 1'b1, 2'd1, 1'b1, CW'('h500));
    for (int n = 0; n < 16; n++) begin
      ready_is("t3_owner_ready", 4'b1000);
      tick();
    end
    chk("t3_credit2_empty", credit(2), 0);
    chk("t3_still_locked", dbg_state_o, 1);
    ready_is("t3_blocked", 4'b0000);
    tick();
    chk("t3_no_flit", chan_valid, 0);
    flow_ctrl_in = ret(2'd2);
    ready_is("t3_same_cycle_return", 4'b0000);
    tick();
    flow_ctrl_in = '0;
    chk("t3_credit2_one", credit(2), 1);
    req_tail[3] = 1'b1;
    ready_is("t3_owner_resumes", 4'b1000);
    tick();
    chk("t3_tail_valid", chan_valid, 1);
    chk("t3_tail_vc", chan_vc, 2);
    chk("t3_unlocked", dbg_state_o, 0);
    ready_is("t3_req0_ready", 4'b0001);
    tick();
    chk("t3_req0_vc", chan_vc, 1);
    chk("t3_req0_data", chan_out, 'h500);
    req_valid = '0;

    // test 4: simultaneous send/return, then overflow on VC0
    set_req(1, 1'b1, 2'd1, 1'b1, CW'('h600));
    for (int n = 0; n < 10; n++) tick();
    chk("t4_credit1_five", credit(1), 5);
    flow_ctrl_in = ret(2'd1);
    ready_is("t4_send_ready", 4'b0010);
    tick();
    flow_ctrl_in = '0;
    req_valid = '0;
    chk("t4_credit1_same", credit(1), 5);
    for (int n = 0; n < 6; n++) begin
      flow_ctrl_in = ret(2'd0);
      tick();
    end
    chk("t4_credit0_full", credit(0), 16);
    chk("t4_no_error_yet", error, 0);
    flow_ctrl_in = ret(2'd0);
    tick();
    flow_ctrl_in = '0;
    chk("t4_credit0_sat", credit(0), 16);
    chk("t4_error_set", error, 1);
    tick();
    tick();
    chk("t4_error_sticky", error, 1);

    // test 5: reset after flit 2 of a four-flit packet
    set_req(2, 1'b1, 2'd3, 1'b0, CW'('h700));
    ready_is("t5_head_ready", 4'b0100);
    tick();
    req_data[2*CW +: CW] = CW'('h701);
    tick();
    chk("t5_flit2_data", chan_out, 'h701);
    chk("t5_locked", dbg_state_o, 1);
    reset = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 2'd0, 1'b1, CW'('h800 + i));
    ready_is("t5_ready_in_reset", 4'b0000);
    tick();
    chk("t5_valid", chan_valid, 0);
    chk("t5_chan_out", chan_out, 0);
    chk("t5_state", dbg_state_o, 0);
    chk("t5_error_clr", error, 0);
    for (int v = 0; v < 4; v++) chk("t5_credit", credit(v), 16);
    reset = 1'b0;
    ready_is("t5_rr_from0", 4'b0001);
    tick();
    chk("t5_first_data", chan_out, 'h800);
    ready_is("t5_rr_next1", 4'b0010);
    tick();
    req_valid = '0;

    // test 6: data path latency
    set_req(2, 1'b1, 2'd3, 1'b1, CW'('h1ABC));
    ready_is("t6_ready", 4'b0100);
    tick();
    chk("t6_data", chan_out, 'h1ABC);
    chk("t6_vc", chan_vc, 3);
    chk("t6_valid", chan_valid, 1);
    req_valid = '0;
    tick();
    chk("t6_idle", chan_valid, 0);
    chk("t6_hold", chan_out, 'h1ABC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
